// File: rtl/debounce_scheduler_if.sv
// Change-event handshake between the debounce scheduler and its consumer.
// The master presents one event at a time; the slave accepts it with event_ready.
interface debounce_scheduler_if #(
  parameter int unsigned N_INPUTS = 8
);
  logic                        event_valid;
  logic                        event_ready;
  logic [$clog2(N_INPUTS)-1:0] event_idx;
  logic                        event_level;

  modport master (
    output event_valid,
    output event_idx,
    output event_level,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_idx,
    input  event_level,
    output event_ready
  );
endinterface

// File: rtl/debounce_scheduler.sv
// Round-robin debounce engine: one shared counter datapath visits each channel in turn,
// and every clean-level change is queued as a pending bit and reported on a valid/ready port.
module debounce_scheduler #(
  parameter int unsigned N_INPUTS    = 8,
  parameter int unsigned CNT_BITS    = 14,
  parameter bit          RESET_LEVEL = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        scan_en_i,
  input  logic [N_INPUTS-1:0]         pb_i,
  output logic [N_INPUTS-1:0]         clean_pb_o,
  output logic [$clog2(N_INPUTS)-1:0] scan_idx_o,
  debounce_scheduler_if.master        ev_o
);

  localparam int unsigned            IdxW    = $clog2(N_INPUTS);
  localparam logic [IdxW-1:0]        LastIdx = IdxW'(N_INPUTS - 1);
  localparam logic [CNT_BITS-1:0]    CntMax  = '1;
  localparam logic [N_INPUTS-1:0]    RstVec  = {N_INPUTS{RESET_LEVEL}};

  logic [N_INPUTS-1:0]               sync1_q, sync2_q;
  logic [IdxW-1:0]                   scan_idx_q, scan_idx_d;
  logic [N_INPUTS-1:0]               last_q, last_d;
  logic [N_INPUTS-1:0]               clean_q, clean_d;
  logic [N_INPUTS-1:0][CNT_BITS-1:0] cnt_q, cnt_d;
  logic [N_INPUTS-1:0]               pending_q, pending_d;
  logic [N_INPUTS-1:0]               pend_set, pend_clr;
  logic                              ev_valid_q, ev_valid_d;
  logic [IdxW-1:0]                   ev_idx_q, ev_idx_d;
  logic                              ev_level_q, ev_level_d;
  logic                              load;
  logic                              found;
  logic [IdxW-1:0]                   sel;

  // Two-flop synchronizer per raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RstVec;
      sync2_q <= RstVec;
    end else begin
      sync1_q <= pb_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    scan_idx_d = scan_idx_q;
    if (scan_en_i) begin
      scan_idx_d = (scan_idx_q == LastIdx) ? '0 : scan_idx_q + 1'b1;
    end
  end

  // Service the channel under the scan pointer; a sample mismatch always restarts the count
  always_comb begin
    last_d   = last_q;
    clean_d  = clean_q;
    cnt_d    = cnt_q;
    pend_set = '0;
    if (scan_en_i) begin
      if (sync2_q[scan_idx_q] != last_q[scan_idx_q]) begin
        last_d[scan_idx_q] = sync2_q[scan_idx_q];
        cnt_d[scan_idx_q]  = '0;
      end else if (cnt_q[scan_idx_q] == CntMax) begin
        if (clean_q[scan_idx_q] != last_q[scan_idx_q]) begin
          clean_d[scan_idx_q]  = last_q[scan_idx_q];
          pend_set[scan_idx_q] = 1'b1;
        end
      end else begin
        cnt_d[scan_idx_q] = cnt_q[scan_idx_q] + 1'b1;
      end
    end
  end

  // Lowest set pending bit wins; descending loop so the last hit is the lowest index
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = int'(N_INPUTS) - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        found = 1'b1;
        sel   = IdxW'(i);
      end
    end
  end

  always_comb begin
    load       = !ev_valid_q || ev_o.event_ready;
    ev_valid_d = ev_valid_q;
    ev_idx_d   = ev_idx_q;
    ev_level_d = ev_level_q;
    pend_clr   = '0;
    if (load) begin
      ev_valid_d = found;
      if (found) begin
        ev_idx_d      = sel;
        ev_level_d    = clean_d[sel];
        pend_clr[sel] = 1'b1;
      end
    end
    // A change landing in the same cycle as the clear must survive
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx_q <= '0;
      last_q     <= RstVec;
      clean_q    <= RstVec;
      cnt_q      <= '0;
      pending_q  <= '0;
      ev_valid_q <= 1'b0;
      ev_idx_q   <= '0;
      ev_level_q <= 1'b0;
    end else begin
      scan_idx_q <= scan_idx_d;
      last_q     <= last_d;
      clean_q    <= clean_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      ev_valid_q <= ev_valid_d;
      ev_idx_q   <= ev_idx_d;
      ev_level_q <= ev_level_d;
    end
  end

  assign clean_pb_o        = clean_q;
  assign scan_idx_o        = scan_idx_q;
  assign ev_o.event_valid  = ev_valid_q;
  assign ev_o.event_idx    = ev_idx_q;
  assign ev_o.event_level  = ev_level_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with 4 channels and a 3-bit counter (8 visits to settle).
module tb_debounce_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned CB = 3;

  logic         clk;
  logic         rst_n;
  logic         scan_en;
  logic [N-1:0] pb;
  logic [N-1:0] clean_pb;
  logic [1:0]   scan_idx;

  int n_checks;
  int n_fail;

  debounce_scheduler_if #(.N_INPUTS(N)) ev_if ();

  debounce_scheduler #(
    .N_INPUTS   (N),
    .CNT_BITS   (CB),
    .RESET_LEVEL(1'b0)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_en_i (scan_en),
    .pb_i      (pb),
    .clean_pb_o(clean_pb),
    .scan_idx_o(scan_idx),
    .ev_o      (ev_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait at negedges until the scan pointer shows s
  task automatic align(input int s);
    int k;
    k = 0;
    while (int'(scan_idx) != s && k < 8) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Count negedges until clean_pb[ch] reaches lvl, giving up after max cycles
  task automatic wait_clean(input int ch, input logic lvl, input int max, output int n);
    n = 0;
    while (clean_pb[ch] !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_valid(input int max);
    int k;
    k = 0;
    while (ev_if.event_valid !== 1'b1 && k < max) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic ready_pulse();
    ev_if.event_ready = 1'b1;
    @(negedge clk);
    ev_if.event_ready = 1'b0;
  endtask

  initial begin
    int   n;
    bit   saw;
    logic [1:0] sidx;
    n_checks          = 0;
    n_fail            = 0;
    rst_n             = 1'b1;
    pb                = '0;
    scan_en           = 1'b1;
    ev_if.event_ready = 1'b0;

    // Reset takes effect between clock edges
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_clean", 32'(clean_pb), 32'h0);
    check_eq("rst_valid", 32'(ev_if.event_valid), 32'h0);
    check_eq("rst_scan_idx", 32'(scan_idx), 32'h0);
    check_eq("rst_event_idx", 32'(ev_if.event_idx), 32'h0);
    check_eq("rst_event_level", 32'(ev_if.event_level), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (ev_if.event_valid) saw = 1'b1;
    end
    check_eq("no_event_after_reset", 32'(saw), 32'h0);
    check_eq("clean_idle", 32'(clean_pb), 32'h0);

    // Single debounce: ch2 mismatch visit lands on the 3rd edge, clean 32 edges later
    align(0);
    pb[2] = 1'b1;
    wait_clean(2, 1'b1, 60, n);
    check_eq("single_latency", 32'(n), 32'd35);
    check_eq("single_clean", 32'(clean_pb), 32'b0100);
    check_eq("single_valid_not_yet", 32'(ev_if.event_valid), 32'h0);
    @(negedge clk);
    check_eq("single_valid", 32'(ev_if.event_valid), 32'h1);
    check_eq("single_idx", 32'(ev_if.event_idx), 32'd2);
    check_eq("single_level", 32'(ev_if.event_level), 32'h1);
    ready_pulse();
    check_eq("single_consumed", 32'(ev_if.event_valid), 32'h0);

    // Bounce: 15 toggles, 20 cycles apart, ending high
    saw = 1'b0;
    for (int t = 0; t < 15; t++) begin
      pb[1] = ~pb[1];
      repeat (20) begin
        @(negedge clk);
        if (ev_if.event_valid || clean_pb[1]) saw = 1'b1;
      end
    end
    check_eq("bounce_no_event", 32'(saw), 32'h0);
    pb[1] = 1'b0;
    pb[1] = 1'b1;
    // pb[1] is already 1 after 15 toggles; time from the last edge seen
    wait_clean(1, 1'b1, 60, n);
    check_eq("bounce_latency_window", 32'((n + 20 >= 35) && (n + 20 <= 38)), 32'h1);
    @(negedge clk);
    check_eq("bounce_valid", 32'(ev_if.event_valid), 32'h1);
    check_eq("bounce_idx", 32'(ev_if.event_idx), 32'd1);
    check_eq("bounce_level", 32'(ev_if.event_level), 32'h1);
    ready_pulse();
    check_eq("bounce_single_event", 32'(ev_if.event_valid), 32'h0);

    // Arbitration under backpressure: ch0 settles before ch3 from this scan phase
    align(2);
    pb[0] = 1'b1;
    pb[3] = 1'b1;
    wait_valid(60);
    check_eq("arb_first_idx", 32'(ev_if.event_idx), 32'd0);
    repeat (10) @(negedge clk);
    check_eq("arb_hold_valid", 32'(ev_if.event_valid), 32'h1);
    check_eq("arb_hold_idx", 32'(ev_if.event_idx), 32'd0);
    check_eq("arb_both_clean", 32'(clean_pb), 32'b1111);
    ready_pulse();
    check_eq("arb_second_valid", 32'(ev_if.event_valid), 32'h1);
    check_eq("arb_second_idx", 32'(ev_if.event_idx), 32'd3);
    check_eq("arb_second_level", 32'(ev_if.event_level), 32'h1);
    ready_pulse();
    check_eq("arb_drained", 32'(ev_if.event_valid), 32'h0);

    // Coalescing: ch3 occupies the port while ch1 changes twice
    pb[3] = 1'b0;
    wait_valid(60);
    check_eq("coal_blocker_idx", 32'(ev_if.event_idx), 32'd3);
    check_eq("coal_blocker_level", 32'(ev_if.event_level), 32'h0);
    pb[1] = 1'b0;
    wait_clean(1, 1'b0, 60, n);
    check_eq("coal_release_seen", 32'(clean_pb[1]), 32'h0);
    pb[1] = 1'b1;
    wait_clean(1, 1'b1, 60, n);
    check_eq("coal_press_seen", 32'(clean_pb[1]), 32'h1);
    check_eq("coal_blocker_stable", 32'(ev_if.event_idx), 32'd3);
    ready_pulse();
    check_eq("coal_valid", 32'(ev_if.event_valid), 32'h1);
    check_eq("coal_idx", 32'(ev_if.event_idx), 32'd1);
    check_eq("coal_level", 32'(ev_if.event_level), 32'h1);
    ready_pulse();
    check_eq("coal_one_event", 32'(ev_if.event_valid), 32'h0);

    // Freeze: 16 enabled edges, pause, then 19 more enabled edges complete the debounce
    align(1);
    pb[3] = 1'b1;
    repeat (16) @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    sidx = scan_idx;
    repeat (100) @(negedge clk);
    check_eq("freeze_scan_idx", 32'(scan_idx), 32'(sidx));
    check_eq("freeze_clean", 32'(clean_pb[3]), 32'h0);
    scan_en = 1'b1;
    wait_clean(3, 1'b1, 60, n);
    check_eq("freeze_remaining", 32'(n), 32'd19);
    @(negedge clk);
    check_eq("freeze_event_idx", 32'(ev_if.event_idx), 32'd3);
    ready_pulse();

    // Reset in the middle of a debounce
    pb[3] = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_clean", 32'(clean_pb), 32'h0);
    check_eq("midrst_valid", 32'(ev_if.event_valid), 32'h0);
    check_eq("midrst_scan_idx", 32'(scan_idx), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("midrst_progress_lost", 32'(clean_pb), 32'h0);
    check_eq("midrst_no_event", 32'(ev_if.event_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
Time-multiplexed debounce engine for a bank of front-panel and radio control inputs: PTT, CW dot/dash and push buttons. One shared counter datapath is sequenced round-robin across N_INPUTS channels; each channel's count, last sample and clean state are held in per-channel registers. Clean levels are exported as a vector. Each clean-state change also produces a change event that is arbitrated onto a single valid/ready event port for the control/status logic.

Parameters:
N_INPUTS, 8, number of debounced channels (2..32)
CNT_BITS, 14, per-channel stability counter width; threshold is all-ones
RESET_LEVEL, 0, clean/last-sample value of every channel after reset (replicated per channel)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
scan_en  input  1  scheduler advance enable
pb  input  N_INPUTS  raw asynchronous button/switch inputs
clean_pb  output  N_INPUTS  debounced levels
event_valid  output  1  change event available
event_ready  input  1  consumer accepts event
event_idx  output  clog2(N_INPUTS)  channel index of event
event_level  output  1  current clean level of that channel
scan_idx  output  clog2(N_INPUTS)  channel serviced this cycle (debug)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). All state clears immediately on rst_n low, independent of clk.
  - Reset values: clean_pb = last = RESET_LEVEL on all channels; counts = 0; pending = 0; event_valid = 0; event_idx = 0; event_level = 0; scan_idx = 0; sync flops = RESET_LEVEL.
  - Reset mid-debounce discards all progress and drops any queued event. No event is generated on reset exit.
- Synchronizer: every pb bit passes through a 2-flop synchronizer, giving s[i]. Fixed 2-cycle latency.
- Scheduler: scan_idx advances by 1 per clk while scan_en = 1 and wraps from N_INPUTS-1 to 0. While scan_en = 0, scan_idx holds and no channel is serviced; state is frozen and the event port keeps working.
- Service of channel i = scan_idx, in priority order:
  - s[i] != last[i]: last <= s[i], count <= 0.
  - else count == all-ones: if clean[i] != last[i], then clean[i] <= last[i] and pending[i] <= 1. Count saturates and holds.
  - else: count <= count + 1.
- Debounce time:
  - clean changes on the 2^CNT_BITS-th consecutive matching visit after the mismatch visit, i.e. 2^CNT_BITS × N_INPUTS cycles with scan_en continuously high.
  - Any mismatch restarts the count.
  - A glitch shorter than one scan period can be missed entirely; this is acceptable.
- Event arbiter, one output register:
  - Load condition: event_valid = 0, or event_valid & event_ready.
  - On load: select the lowest-index set pending bit and set event_idx and event_level = clean[idx] (the value after any same-cycle update). Clear that pending bit and set event_valid = 1.
  - If no pending bit is set on a load cycle, event_valid <= 0.
  - event_idx and event_level are stable while event_valid & !event_ready.
  - Minimum event latency: 1 cycle after the pending bit is set.
- Coalescing:
  - A channel toggling again while its pending bit is set keeps one pending bit.
  - The reported level is the clean level at load time, so a press+release pair pending together reports one event with the final level.
- Simultaneous set and clear of the same pending bit (the new change wins): the bit stays set.
- Starvation: lower indices have priority. The debounce time far exceeds the arbitration time, so no channel can starve.

Test Plan:
1. Reset values with N_INPUTS=4, CNT_BITS=3, RESET_LEVEL=0: assert rst_n=0 asynchronously between clock edges -> clean_pb=0000, event_valid=0 immediately; release rst_n with pb=0000 -> no event in 200 cycles.
2. Single debounce, same config: pb[2] 0->1 and held -> clean_pb[2] rises 32 cycles (8 visits × 4) after the first mismatch visit (+2 synchronizer cycles); event_valid with event_idx=2, event_level=1; pulse event_ready -> event_valid=0.
3. Bounce rejection: pb[1] toggles every 20 cycles for 300 cycles, then is held at 1 -> no event during bouncing; exactly one event (idx 1, level 1) 32 cycles after the last edge is seen.
4. Backpressure and arbitration: pb[0] and pb[3] rise together with event_ready=0 -> event_idx=0 is presented and holds stable; after one ready cycle -> event_idx=3, level=1; after the next ready -> event_valid=0.
5. Coalescing: event_ready=0, pb[1] press, debounce completes, then release and debounce again -> on ready exactly one event: idx 1, level 0.
6. scan_en low for 100 cycles mid-debounce -> scan_idx frozen and clean_pb unchanged; debounce completes after the remaining visits once scan_en returns high. Reset asserted mid-debounce -> count lost, clean_pb returns to 0000.
